// File: rtl/crosspoint_cfg.sv
// Serially configured N_IN x N_OUT crosspoint: every output is the OR of a chosen
// subset of inputs plus a constant-1 column. A shadow matrix is loaded bit-serially and copied to the active matrix by COMMIT.
module crosspoint_cfg #(
  parameter int                N_IN     = 48,
  parameter int                N_OUT    = 48,
  parameter logic [N_OUT-1:0]  INV_MASK = '0,
  parameter int                ADDR_W   = $clog2(N_OUT * (N_IN + 1)),
  parameter int                CMD_W    = ADDR_W + 3
) (
  input  logic             clk_,
  input  logic             clear,
  input  logic             sel,
  input  logic             dat,
  input  logic [N_IN-1:0]  inp,
  output logic [N_OUT-1:0] outp,
  output logic             dout,
  output logic             err,
  output logic             commit_pulse
);

  localparam int N_COL  = N_IN + 1;
  localparam int N_BITS = N_OUT * N_COL;
  localparam int CNT_W  = $clog2(CMD_W + 1);

  localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(N_BITS - 1);
  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(CMD_W - 1);
  localparam logic [CNT_W-1:0]  CNT_FULL  = CNT_W'(CMD_W);

  typedef enum logic [1:0] {
    OP_WRITE  = 2'b00,
    OP_READ   = 2'b01,
    OP_COMMIT = 2'b10,
    OP_CLEAR  = 2'b11
  } op_e;

  logic [N_BITS-1:0] shadow_q, shadow_d;
  logic [N_BITS-1:0] active_q, active_d;
  // Only CMD_W-1 bits are stored: the final bit is taken straight from dat on
  // the executing edge, and once the count saturates the word is never read.
  logic [CMD_W-2:0]  word_q, word_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              dout_q, dout_d;
  logic              err_q, err_d;
  logic              commit_pulse_q, commit_pulse_d;

  logic [CMD_W-1:0]  word_in;
  op_e               op;
  logic [ADDR_W-1:0] addr;
  logic              d_bit;
  logic              addr_ok;
  logic              exec;

  assign word_in = {dat, word_q};
  assign op      = op_e'(word_in[1:0]);
  assign addr    = word_in[ADDR_W+1:2];
  assign d_bit   = word_in[CMD_W-1];
  assign addr_ok = (addr <= ADDR_LAST);
  assign exec    = sel && (cnt_q == CNT_LAST);

  always_comb begin
    shadow_d       = shadow_q;
    active_d       = active_q;
    word_d         = word_q;
    cnt_d          = cnt_q;
    dout_d         = dout_q;
    err_d          = err_q;
    commit_pulse_d = 1'b0;

    if (!sel) begin
      cnt_d = '0;
    end else if (cnt_q != CNT_FULL) begin
      word_d = word_in[CMD_W-1:1];
      cnt_d  = cnt_q + 1'b1;
    end

    if (exec) begin
      case (op)
        OP_WRITE: begin
          if (addr_ok) shadow_d[addr] = d_bit;
          else         err_d = 1'b1;
        end
        OP_READ: begin
          if (addr_ok) dout_d = shadow_q[addr];
          else begin
            dout_d = 1'b0;
            err_d  = 1'b1;
          end
        end
        OP_COMMIT: begin
          active_d       = shadow_q;
          commit_pulse_d = 1'b1;
        end
        OP_CLEAR: shadow_d = '0;
        default: ;
      endcase
    end
  end

  always_ff @(negedge clk_) begin
    if (clear) begin
      shadow_q       <= '0;
      active_q       <= '0;
      word_q         <= '0;
      cnt_q          <= '0;
      dout_q         <= 1'b0;
      err_q          <= 1'b0;
      commit_pulse_q <= 1'b0;
    end else begin
      shadow_q       <= shadow_d;
      active_q       <= active_d;
      word_q         <= word_d;
      cnt_q          <= cnt_d;
      dout_q         <= dout_d;
      err_q          <= err_d;
      commit_pulse_q <= commit_pulse_d;
    end
  end

  // Column 0 of every row is the constant-1 term, columns 1..N_IN are inp.
  for (genvar o = 0; o < N_OUT; o++) begin : g_out
    assign outp[o] = INV_MASK[o] ^ (|(active_q[o*N_COL +: N_COL] & {inp, 1'b1}));
  end

  assign dout         = dout_q;
  assign err          = err_q;
  assign commit_pulse = commit_pulse_q;

endmodule

// File: tb/tb_crosspoint_cfg.sv
// Directed bench for crosspoint_cfg: one default instance and one with INV_MASK=1,
// with expected observations queued by the driver and checked by a posedge monitor.
module tb_crosspoint_cfg;

  localparam logic [47:0] O47 = 48'h8000_0000_0000;
  localparam int          OBS_W = 102;

  logic        clk_ = 1'b1;
  logic        clear = 1'b1;
  logic        sel_a = 1'b0;
  logic        sel_b = 1'b0;
  logic        dat = 1'b0;
  logic [47:0] inp = '1;

  logic [47:0] outp_a, outp_b;
  logic        dout_a, err_a, cp_a;
  logic        dout_b, err_b, cp_b;
  logic [OBS_W-1:0] obs;

  logic [OBS_W-1:0] exp_q[$];
  string            name_q[$];
  int               n_cmp = 0;
  int               n_bad = 0;

  crosspoint_cfg dut_a (
    .clk_(clk_), .clear(clear), .sel(sel_a), .dat(dat), .inp(inp),
    .outp(outp_a), .dout(dout_a), .err(err_a), .commit_pulse(cp_a)
  );

  crosspoint_cfg #(.INV_MASK(48'h1)) dut_b (
    .clk_(clk_), .clear(clear), .sel(sel_b), .dat(dat), .inp(inp),
    .outp(outp_b), .dout(dout_b), .err(err_b), .commit_pulse(cp_b)
  );

  assign obs = {outp_b, dout_b, err_b, cp_b, outp_a, dout_a, err_a, cp_a};

  // Clock / reset: state moves on the falling edge at 5, 15, 25 ...
  always #5 clk_ = ~clk_;

  // Monitor: everything queued during a cycle describes the state after the
  // falling edge that follows, so it is checked at the next rising edge.
  logic [OBS_W-1:0] mon_e;
  string            mon_n;
  always @(posedge clk_) begin
    while (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      mon_n = name_q.pop_front();
      n_cmp++;
      if (obs !== mon_e) begin
        n_bad++;
        $display("FAIL %s: got %h expected %h", mon_n, obs, mon_e);
      end
    end
  end

  // Driver tasks
  task automatic tick();
    @(posedge clk_);
    #2;
  endtask

  function automatic logic [14:0] mkw(input logic [1:0] op, input logic [11:0] a, input logic d);
    return {d, a, op};
  endfunction

  task automatic shift(input logic [19:0] w, input int lo, input int hi, input bit to_b);
    for (int i = lo; i < hi; i++) begin
      tick();
      sel_a = !to_b;
      sel_b = to_b;
      dat   = w[i];
    end
  endtask

  task automatic gap();
    tick();
    sel_a = 1'b0;
    sel_b = 1'b0;
    dat   = 1'b0;
  endtask

  task automatic exp_ab(input string nm, input logic [47:0] oa, input logic da, input logic ea,
                        input logic ca, input logic [47:0] ob, input logic db, input logic eb,
                        input logic cb);
    exp_q.push_back({ob, db, eb, cb, oa, da, ea, ca});
    name_q.push_back(nm);
  endtask

  task automatic exp_a(input string nm, input logic [47:0] oa, input logic da, input logic ea,
                       input logic ca);
    exp_ab(nm, oa, da, ea, ca, 48'h1, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic frame(input logic [14:0] w, input bit to_b);
    shift({5'b0, w}, 0, 15, to_b);
  endtask

  logic [19:0] w20;

  initial begin
    // Reset with every input high
    tick();
    clear = 1'b1;
    inp   = '1;
    exp_a("reset", '0, 1'b0, 1'b0, 1'b0);
    tick();
    clear = 1'b0;

    // WRITE o=1 c=6 (inp[5]) has no effect until COMMIT
    frame(mkw(2'b00, 12'd55, 1'b1), 1'b0);
    exp_a("write_no_effect", '0, 1'b0, 1'b0, 1'b0);
    gap();
    frame(mkw(2'b10, 12'd0, 1'b0), 1'b0);
    exp_a("commit_pulse", 48'h2, 1'b0, 1'b0, 1'b1);
    gap();
    exp_a("commit_pulse_clear", 48'h2, 1'b0, 1'b0, 1'b0);
    tick();
    inp = '0;
    exp_a("inp5_low", '0, 1'b0, 1'b0, 1'b0);
    tick();
    inp = 48'h20;
    exp_a("inp5_only", 48'h2, 1'b0, 1'b0, 1'b0);
    tick();
    inp = ~48'h20;
    exp_a("others_high", '0, 1'b0, 1'b0, 1'b0);

    // Constant column, then CLEAR_SHADOW leaves active alone until COMMIT
    frame(mkw(2'b00, 12'd0, 1'b1), 1'b0);
    gap();
    frame(mkw(2'b10, 12'd0, 1'b0), 1'b0);
    exp_a("const_col", 48'h1, 1'b0, 1'b0, 1'b1);
    gap();
    frame(mkw(2'b11, 12'd0, 1'b0), 1'b0);
    exp_a("clear_shadow_keeps_active", 48'h1, 1'b0, 1'b0, 1'b0);
    gap();
    frame(mkw(2'b10, 12'd0, 1'b0), 1'b0);
    exp_a("commit_empty", '0, 1'b0, 1'b0, 1'b1);
    gap();
    tick();
    inp = '1;
    exp_a("all_routes_off", '0, 1'b0, 1'b0, 1'b0);

    // Last valid address, then first invalid one
    frame(mkw(2'b00, 12'd2351, 1'b1), 1'b0);
    exp_a("write_last_addr", '0, 1'b0, 1'b0, 1'b0);
    gap();
    frame(mkw(2'b01, 12'd2351, 1'b0), 1'b0);
    exp_a("read_last_addr", '0, 1'b1, 1'b0, 1'b0);
    gap();
    exp_a("dout_holds", '0, 1'b1, 1'b0, 1'b0);
    frame(mkw(2'b00, 12'd2352, 1'b1), 1'b0);
    exp_a("write_bad_addr", '0, 1'b1, 1'b1, 1'b0);
    gap();
    frame(mkw(2'b01, 12'd2352, 1'b1), 1'b0);
    exp_a("read_bad_addr", '0, 1'b0, 1'b1, 1'b0);
    gap();
    frame(mkw(2'b10, 12'd0, 1'b0), 1'b0);
    exp_a("commit_after_bad", O47, 1'b0, 1'b1, 1'b1);
    gap();

    // 14-bit frame is discarded
    shift({5'b0, mkw(2'b00, 12'd0, 1'b1)}, 0, 14, 1'b0);
    gap();
    frame(mkw(2'b10, 12'd0, 1'b0), 1'b0);
    exp_a("short_frame_discarded", O47, 1'b0, 1'b1, 1'b1);
    gap();

    // 20-bit frames: execute once on bit 15, ignore the rest
    shift({5'b11111, mkw(2'b00, 12'd0, 1'b1)}, 0, 20, 1'b0);
    exp_a("long_write", O47, 1'b0, 1'b1, 1'b0);
    gap();
    w20 = {5'b01010, mkw(2'b10, 12'd0, 1'b0)};
    shift(w20, 0, 15, 1'b0);
    exp_a("long_commit", O47 | 48'h1, 1'b0, 1'b1, 1'b1);
    for (int i = 15; i < 20; i++) begin
      shift(w20, i, i + 1, 1'b0);
      exp_a("long_no_reexec", O47 | 48'h1, 1'b0, 1'b1, 1'b0);
    end
    gap();

    // Back-to-back frames with one sel-low cycle between them
    frame(mkw(2'b00, 12'd55, 1'b1), 1'b0);
    gap();
    frame(mkw(2'b10, 12'd0, 1'b0), 1'b0);
    exp_a("back_to_back", O47 | 48'h3, 1'b0, 1'b1, 1'b1);
    gap();

    // Inverting instance: route inp[0] to outp[0]
    frame(mkw(2'b00, 12'd1, 1'b1), 1'b1);
    gap();
    frame(mkw(2'b10, 12'd0, 1'b0), 1'b1);
    exp_ab("inv_commit", O47 | 48'h3, 1'b0, 1'b1, 1'b0, '0, 1'b0, 1'b0, 1'b1);
    gap();
    exp_ab("inv_pulse_clear", O47 | 48'h3, 1'b0, 1'b1, 1'b0, '0, 1'b0, 1'b0, 1'b0);
    tick();
    inp = '0;
    exp_ab("inv_inp0_low", 48'h1, 1'b0, 1'b1, 1'b0, 48'h1, 1'b0, 1'b0, 1'b0);
    tick();
    inp = '1;
    exp_ab("inv_inp0_high", O47 | 48'h3, 1'b0, 1'b1, 1'b0, '0, 1'b0, 1'b0, 1'b0);

    // Clear in the middle of a COMMIT frame, then finish its bits
    w20 = {5'b0, mkw(2'b10, 12'd0, 1'b0)};
    shift(w20, 0, 8, 1'b1);
    tick();
    clear = 1'b1;
    exp_ab("clear_mid_frame", '0, 1'b0, 1'b0, 1'b0, 48'h1, 1'b0, 1'b0, 1'b0);
    tick();
    clear = 1'b0;
    shift(w20, 8, 15, 1'b1);
    exp_ab("partial_discarded", '0, 1'b0, 1'b0, 1'b0, 48'h1, 1'b0, 1'b0, 1'b0);
    gap();
    exp_ab("after_partial", '0, 1'b0, 1'b0, 1'b0, 48'h1, 1'b0, 1'b0, 1'b0);

    // Report
    tick();
    tick();
    if (exp_q.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
